// File: rtl/spi_slave_16.sv
// spi_slave_16: 16-bit CPOL=0 / CPHA=0 SPI responder.
// spi_sclk, spi_cs_l and mosi are oversampled on clk through an optional
// synchroniser. Each frame shifts one MOSI word in and a preloaded MISO word
// out. The received word is presented with a one-cycle rx_valid strobe.
// Optional feature macro: SPI_SLAVE_MISO_TRISTATE_EN. When it is defined,
// miso is released to high-Z while chip select is high or the slave is idle.
module spi_slave_16 #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs_l,
  input  logic        spi_sclk,
  input  logic        mosi,
  output logic        miso,
  input  logic [15:0] tx_data,
  input  logic        tx_load,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CNT_W   = 5;
  localparam int unsigned FLUSH_W = (SYNC_STAGES > 0) ? $clog2(SYNC_STAGES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Synchronised pin samples
  logic cs_s;
  logic sclk_s;
  logic mosi_s;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      // Master shares clk: its outputs are already registered in this domain
      assign cs_s   = spi_cs_l;
      assign sclk_s = spi_sclk;
      assign mosi_s = mosi;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] cs_sync_q;
      logic [SYNC_STAGES-1:0] sclk_sync_q;
      logic [SYNC_STAGES-1:0] mosi_sync_q;

      // Multi-flop synchroniser chains; CS resets to its inactive (high) level
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cs_sync_q   <= '1;
          sclk_sync_q <= '0;
          mosi_sync_q <= '0;
        end else begin
          cs_sync_q[0]   <= spi_cs_l;
          sclk_sync_q[0] <= spi_sclk;
          mosi_sync_q[0] <= mosi;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            cs_sync_q[i]   <= cs_sync_q[i-1];
            sclk_sync_q[i] <= sclk_sync_q[i-1];
            mosi_sync_q[i] <= mosi_sync_q[i-1];
          end
        end
      end

      assign cs_s   = cs_sync_q[SYNC_STAGES-1];
      assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
      assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // After reset the synchroniser still holds its reset value (CS high) for
  // SYNC_STAGES cycles. Those samples must not count as "CS seen high",
  // otherwise a CS held low through reset would look like a fresh frame.
  logic [FLUSH_W-1:0] flush_cnt_q;
  logic               flush_done;

  assign flush_done = (flush_cnt_q == FLUSH_W'(SYNC_STAGES));

  // Count the synchroniser flush after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt_q <= '0;
    end else if (!flush_done) begin
      flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
    end
  end

  // Previous-sample registers for edge detection
  logic cs_prev_q;
  logic sclk_prev_q;

  // One-cycle history of synced CS and SCLK
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_prev_q   <= flush_done ? cs_s : 1'b0;
      sclk_prev_q <= sclk_s;
    end
  end

  logic cs_fall;
  logic cs_rise;
  logic sclk_rise;
  logic sclk_fall;

  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s & flush_done;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  // State and datapath registers
  state_e            state_q,    state_d;
  logic [DATA_W-1:0] tx_buf_q,   tx_buf_d;
  logic [DATA_W-1:0] tx_sh_q,    tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q,    rx_sh_d;
  logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic              miso_q,     miso_d;
  logic [DATA_W-1:0] rx_data_q,  rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q,     busy_d;

  // Helper terms for the datapath
  logic [DATA_W-1:0] tx_word;
  logic [DATA_W-1:0] rx_word;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last_rise;
  logic              cnt_open;

  // A tx_load coinciding with the CS fall supplies the word for this frame
  assign tx_word   = tx_load ? tx_data : tx_buf_q;
  assign rx_word   = (rx_sh_q << 1) | DATA_W'(mosi_s);
  assign cnt_open  = (bit_cnt_q < CNT_W'(DATA_W));
  assign cnt_inc   = cnt_open ? (bit_cnt_q + CNT_W'(1)) : bit_cnt_q;
  assign last_rise = (bit_cnt_q == CNT_W'(DATA_W - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a CS rise takes priority over any sclk edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sclk_rise && last_rise) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    tx_buf_d    = tx_load ? tx_data : tx_buf_q;
    tx_sh_d     = tx_sh_q;
    rx_sh_d     = rx_sh_q;
    bit_cnt_d   = bit_cnt_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          tx_sh_d   = tx_word;
          miso_d    = tx_word[DATA_W-1];
          bit_cnt_d = '0;
          rx_sh_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          frame_err_d = cnt_open;
        end else if (sclk_rise) begin
          rx_sh_d   = rx_word;
          bit_cnt_d = cnt_inc;
          if (last_rise) begin
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall && cnt_open) begin
          tx_sh_d = tx_sh_q << 1;
          miso_d  = tx_sh_q[DATA_W-2];
        end
      end
      default: begin
        // DONE: sclk edges ignored, miso holds
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_buf_q    <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      bit_cnt_q   <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      tx_buf_q    <= tx_buf_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  // Release the shared MISO line whenever this slave is not selected
  assign miso = (cs_s || (state_q == ST_IDLE)) ? 1'bz : miso_q;
`else
  assign miso = miso_q;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_16.sv
// tb_spi_slave_16: scoreboard bench for spi_slave_16.
// Two instances share one bit-banged SPI bus: u_dut0 (SYNC_STAGES=0) and
// u_dut2 (SYNC_STAGES=2). u_dut2's chip select can be masked off (en2=0)
// for frames that are too fast for it or timed for u_dut0 only.
module tb_spi_slave_16;

  typedef struct packed {
    logic        err;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cs_l;
  logic        sclk;
  logic        mosi_b;
  logic        en2;
  logic        tx_load;
  logic [15:0] tx_data;
  logic        cs2_l;

  logic        miso0, miso2;
  logic [15:0] rx_data0, rx_data2;
  logic        rx_valid0, rx_valid2;
  logic        frame_err0, frame_err2;
  logic        busy0, busy2;

  assign cs2_l = cs_l | ~en2;

  spi_slave_16 #(.SYNC_STAGES(0)) u_dut0 (
    .clk(clk), .reset(reset), .spi_cs_l(cs_l), .spi_sclk(sclk), .mosi(mosi_b),
    .miso(miso0), .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .frame_err(frame_err0), .busy(busy0)
  );

  spi_slave_16 #(.SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .reset(reset), .spi_cs_l(cs2_l), .spi_sclk(sclk), .mosi(mosi_b),
    .miso(miso2), .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .frame_err(frame_err2), .busy(busy2)
  );

  exp_t q0[$];
  exp_t q2[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] d);
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
  endtask

  task automatic push(input bit to0, input bit to2, input logic err, input logic [15:0] d);
    exp_t e;
    e.err  = err;
    e.data = d;
    if (to0) q0.push_back(e);
    if (to2) q2.push_back(e);
  endtask

  // Scoreboard monitor for u_dut0
  task automatic mon0();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (rx_valid0 || frame_err0)) begin
        n_cmp++;
        if (q0.size() == 0) begin
          n_err++;
          $display("FAIL dut0_strobe: unexpected rx_valid=%b frame_err=%b rx_data=%h",
                   rx_valid0, frame_err0, rx_data0);
        end else begin
          e = q0.pop_front();
          if (frame_err0 !== e.err || rx_valid0 !== ~e.err || rx_data0 !== e.data) begin
            n_err++;
            $display("FAIL dut0_strobe: got err=%b valid=%b data=%h expected err=%b data=%h",
                     frame_err0, rx_valid0, rx_data0, e.err, e.data);
          end
        end
      end
    end
  endtask

  // Scoreboard monitor for u_dut2
  task automatic mon2();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (rx_valid2 || frame_err2)) begin
        n_cmp++;
        if (q2.size() == 0) begin
          n_err++;
          $display("FAIL dut2_strobe: unexpected rx_valid=%b frame_err=%b rx_data=%h",
                   rx_valid2, frame_err2, rx_data2);
        end else begin
          e = q2.pop_front();
          if (frame_err2 !== e.err || rx_valid2 !== ~e.err || rx_data2 !== e.data) begin
            n_err++;
            $display("FAIL dut2_strobe: got err=%b valid=%b data=%h expected err=%b data=%h",
                     frame_err2, rx_valid2, rx_data2, e.err, e.data);
          end
        end
      end
    end
  endtask

  // Bit-banged CPOL=0/CPHA=0 frame; MISO is captured just before each rise
  task automatic frame(input logic [15:0] w, input int nbits, input int ph,
                       input int load_at, input logic [15:0] load_d, input bit mid_load,
                       input bit chk_miso, input logic [15:0] exp0, input logic [15:0] exp2);
    logic [15:0] got0;
    logic [15:0] got2;
    got0   = '0;
    got2   = '0;
    cs_l   = 1'b0;
    mosi_b = w[15];
    for (int k = 0; k < ph; k++) begin
      if (k == load_at) begin
        tx_data = load_d;
        tx_load = 1'b1;
      end
      @(negedge clk);
      tx_load = 1'b0;
    end
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) begin
        got0[15-i] = miso0;
        got2[15-i] = miso2;
      end
      sclk = 1'b1;
      cyc(ph);
      if (i == 0) begin
        check("busy0_in_frame", 16'(busy0), 16'd1);
        if (en2) check("busy2_in_frame", 16'(busy2), 16'd1);
      end
      sclk   = 1'b0;
      mosi_b = (i + 1 < 16) ? w[14-i] : 1'b1;
      if (mid_load && i == 7) begin
        tx_data = 16'h0000;
        tx_load = 1'b1;
      end
      @(negedge clk);
      tx_load = 1'b0;
      cyc(ph - 1);
    end
    cs_l = 1'b1;
    cyc(2 * ph + 4);
    if (chk_miso) begin
      check("miso_word0", got0, exp0);
      if (en2) check("miso_word2", got2, exp2);
    end
  endtask

  initial begin
    reset   = 1'b1;
    cs_l    = 1'b1;
    sclk    = 1'b0;
    mosi_b  = 1'b0;
    en2     = 1'b0;
    tx_load = 1'b0;
    tx_data = '0;
    fork
      mon0();
      mon2();
    join_none
    cyc(3);
    reset = 1'b0;
    cyc(4);

    // Reset state
    check("rst_rx_data0",   rx_data0,          16'h0000);
    check("rst_rx_data2",   rx_data2,          16'h0000);
    check("rst_rx_valid0",  16'(rx_valid0),    16'd0);
    check("rst_frame_err2", 16'(frame_err2),   16'd0);
    check("rst_busy0",      16'(busy0),        16'd0);
    check("rst_busy2",      16'(busy2),        16'd0);
    check("rst_miso0",      16'(miso0),        16'd0);
    check("rst_miso2",      16'(miso2),        16'd0);

    // Same-clock master at one clk per phase (u_dut0 only)
    en2 = 1'b0;
    load(16'h3C5A);
    push(1'b1, 1'b0, 1'b0, 16'hA5C3);
    frame(16'hA5C3, 16, 1, -1, 16'h0000, 1'b0, 1'b1, 16'h3C5A, 16'h0000);

    // Synchronised slave, 4 clk per phase
    en2 = 1'b1;
    cyc(8);
    load(16'h0001);
    push(1'b1, 1'b1, 1'b0, 16'hFFFF);
    frame(16'hFFFF, 16, 4, -1, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'h0001);

    // Short frame: frame_err, rx_data keeps FFFF; then a good frame
    push(1'b1, 1'b1, 1'b1, 16'hFFFF);
    frame(16'h5555, 7, 4, -1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("err_keep_rx0", rx_data0, 16'hFFFF);
    check("err_keep_rx2", rx_data2, 16'hFFFF);
    load(16'hC3A5);
    push(1'b1, 1'b1, 1'b0, 16'h1234);
    frame(16'h1234, 16, 4, -1, 16'h0000, 1'b0, 1'b1, 16'hC3A5, 16'hC3A5);

    // tx_load in the CS-fall detect cycle of u_dut0, plus a mid-frame load of 0
    load(16'h1111);
    en2 = 1'b0;
    push(1'b1, 1'b0, 1'b0, 16'h0F0F);
    frame(16'h0F0F, 16, 4, 0, 16'hBEEF, 1'b1, 1'b1, 16'hBEEF, 16'h0000);

    // tx_load in the CS-fall detect cycle of u_dut2; u_dut0 has already started
    en2 = 1'b1;
    cyc(8);
    push(1'b1, 1'b1, 1'b0, 16'hF00F);
    frame(16'hF00F, 16, 4, 2, 16'hBEEF, 1'b1, 1'b1, 16'h0000, 16'hBEEF);

    // Reset mid-frame with CS held low through release
    cs_l   = 1'b0;
    mosi_b = 1'b1;
    cyc(4);
    for (int j = 0; j < 3; j++) begin
      sclk = 1'b1; cyc(4);
      sclk = 1'b0; cyc(4);
    end
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(4);
    check("rstmid_busy0", 16'(busy0), 16'd0);
    check("rstmid_busy2", 16'(busy2), 16'd0);
    for (int j = 0; j < 4; j++) begin
      sclk = 1'b1; cyc(4);
      sclk = 1'b0; cyc(4);
    end
    check("rstmid_busy0_after_sclk", 16'(busy0), 16'd0);
    check("rstmid_busy2_after_sclk", 16'(busy2), 16'd0);
    check("rstmid_rx0", rx_data0, 16'h0000);
    check("rstmid_rx2", rx_data2, 16'h0000);
    cs_l = 1'b1;
    cyc(8);
    load(16'h5AA5);
    push(1'b1, 1'b1, 1'b0, 16'hA5A5);
    frame(16'hA5A5, 16, 4, -1, 16'h0000, 1'b0, 1'b1, 16'h5AA5, 16'h5AA5);

    // 18 pulses: one strobe, extra edges ignored, miso holds the last bit
    load(16'h6DB7);
    push(1'b1, 1'b1, 1'b0, 16'h8001);
    frame(16'h8001, 18, 4, -1, 16'h0000, 1'b0, 1'b1, 16'h6DB7, 16'h6DB7);
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    check("miso0_released", 16'(miso0), 16'(1'bz));
    check("miso2_released", 16'(miso2), 16'(1'bz));
`else
    check("miso0_hold", 16'(miso0), 16'd1);
    check("miso2_hold", 16'(miso2), 16'd1);
`endif

    cyc(10);
    check("q0_drained", 16'(q0.size()), 16'd0);
    check("q2_drained", 16'(q2.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
